dot_general_int: RTL and testbench

//  MX-style block-scaled integer dot product of two length-C vectors.
//  - Vectors split into C/k blocks; each block carries one 8-bit biased power-of-two

---
 rtl/mx_pkg.sv | 20 ++
 rtl/dot_block_int.sv | 26 ++
 rtl/dot_general_int.sv | 114 +++++++++++
 tb/tb_dot_general_int.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mx_pkg.sv
// rtl/mx_pkg.sv - shared scale constants, scale type and exponent clamp helper
package mx_pkg;

  localparam int SCALE_W    = 8;
  localparam int SCALE_BIAS = 127;

  typedef logic [SCALE_W-1:0] scale_t;

  // Saturate a 10-bit signed exponent sum into the unsigned 8-bit scale range
  function automatic scale_t clamp_exp(input logic signed [9:0] e);
    if (e < 10'sd0) begin
      return scale_t'(0);
    end else if (e > 10'sd255) begin
      return scale_t'(255);
    end else begin
      return e[SCALE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/dot_block_int.sv
// rtl/dot_block_int.sv - combinational signed dot product of one k-element block
module dot_block_int
  import mx_pkg::*;
#(
  parameter int k         = 2,
  parameter int bit_width = 8,
  parameter int out_width = 2*bit_width + $clog2(k)
) (
  input  logic signed [bit_width-1:0] i_x [k],
  input  logic signed [bit_width-1:0] i_y [k],
  output logic signed [out_width-1:0] o_p
);

  // Sign-extend first so every product and partial sum is exact at out_width
  always_comb begin
    logic signed [out_width-1:0] w_xe;
    logic signed [out_width-1:0] w_ye;
    o_p = '0;
    for (int m = 0; m < k; m++) begin
      w_xe = out_width'(i_x[m]);
      w_ye = out_width'(i_y[m]);
      o_p  = o_p + w_xe * w_ye;
    end
  end

endmodule

// File: rtl/dot_general_int.sv
// rtl/dot_general_int.sv - block-scaled integer dot product with shared output scale
module dot_general_int
  import mx_pkg::*;
#(
  parameter int C         = 4,
  parameter int k         = 2,
  parameter int bit_width = 8,
  parameter int out_width = 2*bit_width + $clog2(k)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic signed [bit_width-1:0] i_X [C],
  input  logic signed [bit_width-1:0] i_Y [C],
  input  scale_t                      i_S [C/k],
  input  scale_t                      i_T [C/k],
  output logic signed [out_width-1:0] o_dp,
  output scale_t                      o_scale
);

  localparam int BLOCK_COUNT = C / k;
  localparam int ACC_W       = out_width + $clog2(BLOCK_COUNT) + 1;

  // Saturation bounds of the signed out_width result, expressed at accumulator width
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-out_width+1){1'b0}}, {(out_width-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-out_width+1){1'b1}}, {(out_width-1){1'b0}}};

  logic signed [out_width-1:0] w_p   [BLOCK_COUNT];
  logic signed [out_width-1:0] w_a   [BLOCK_COUNT];
  scale_t                      w_e   [BLOCK_COUNT];
  scale_t                      w_sh  [BLOCK_COUNT];
  scale_t                      w_emax;
  logic signed [ACC_W-1:0]     w_acc;
  logic signed [out_width-1:0] w_sat;
  logic signed [out_width-1:0] r_dp;
  scale_t                      r_scale;

  for (genvar j = 0; j < BLOCK_COUNT; j++) begin : g_blk
    logic signed [bit_width-1:0] w_xb [k];
    logic signed [bit_width-1:0] w_yb [k];
    for (genvar m = 0; m < k; m++) begin : g_el
      assign w_xb[m] = i_X[j*k+m];
      assign w_yb[m] = i_Y[j*k+m];
    end
    dot_block_int #(
      .k         (k),
      .bit_width (bit_width),
      .out_width (out_width)
    ) u_blk (
      .i_x (w_xb),
      .i_y (w_yb),
      .o_p (w_p[j])
    );
  end

  // Per-block exponent: biased sum rebiased once, then clamped into scale range
  always_comb begin
    for (int j = 0; j < BLOCK_COUNT; j++) begin
      w_e[j] = clamp_exp($signed({2'b00, i_S[j]}) + $signed({2'b00, i_T[j]})
                         - 10'(SCALE_BIAS));
    end
  end

  // Largest block exponent becomes the shared output scale
  always_comb begin
    w_emax = w_e[0];
    for (int j = 1; j < BLOCK_COUNT; j++) begin
      if (w_e[j] > w_emax) w_emax = w_e[j];
    end
  end

  // Align each block to the shared scale; oversized shifts collapse to the sign fill
  always_comb begin
    for (int j = 0; j < BLOCK_COUNT; j++) begin
      w_sh[j] = w_emax - w_e[j];
      if (int'(w_sh[j]) >= out_width) begin
        w_a[j] = {out_width{w_p[j][out_width-1]}};
      end else begin
        w_a[j] = w_p[j] >>> w_sh[j];
      end
    end
  end

  // Wide accumulation of aligned blocks, then clip to the output range
  always_comb begin
    w_acc = '0;
    for (int j = 0; j < BLOCK_COUNT; j++) begin
      w_acc = w_acc + ACC_W'(w_a[j]);
    end
    if (w_acc > SAT_MAX) begin
      w_sat = SAT_MAX[out_width-1:0];
    end else if (w_acc < SAT_MIN) begin
      w_sat = SAT_MIN[out_width-1:0];
    end else begin
      w_sat = w_acc[out_width-1:0];
    end
  end

  // Output register; reset wins over incoming data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dp    <= '0;
      r_scale <= '0;
    end else begin
      r_dp    <= w_sat;
      r_scale <= w_emax;
    end
  end

  assign o_dp    = r_dp;
  assign o_scale = r_scale;

endmodule

// File: tb/tb_dot_general_int.sv
// tb/tb_dot_general_int.sv - scoreboard bench for dot_general_int
module tb_dot_general_int;
  import mx_pkg::*;

  localparam int C   = 4;
  localparam int K   = 2;
  localparam int BW  = 8;
  localparam int OW  = 17;
  localparam int NB  = C / K;

  typedef struct {
    int    dp;
    int    scale;
    string name;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic signed [BW-1:0] x [C];
  logic signed [BW-1:0] y [C];
  scale_t               s [NB];
  scale_t               t [NB];
  logic signed [OW-1:0] dp;
  scale_t               scale;

  exp_t q[$];
  bit   issued;
  int   checks;
  int   passes;

  dot_general_int #(
    .C         (C),
    .k         (K),
    .bit_width (BW),
    .out_width (OW)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_X     (x),
    .i_Y     (y),
    .i_S     (s),
    .i_T     (t),
    .o_dp    (dp),
    .o_scale (scale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every edge that captured an issued vector must match the queue head
  initial begin
    bit   v;
    exp_t e;
    forever begin
      @(posedge clk);
      v = issued;
      #1;
      if (v) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_output dp=%0d scale=%0d (no expectation queued)", dp, scale);
        end else begin
          e = q.pop_front();
          if (int'(dp) == e.dp && int'(scale) == e.scale) begin
            passes++;
          end else begin
            $display("FAIL %s: got dp=%0d scale=%0d, expected dp=%0d scale=%0d",
                     e.name, dp, scale, e.dp, e.scale);
          end
        end
      end
    end
  end

  task automatic apply(input int xv[C], input int yv[C], input int sv[NB], input int tv[NB],
                       input bit r, input int edp, input int esc, input string nm);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < C; i++) begin
      x[i] = BW'(xv[i]);
      y[i] = BW'(yv[i]);
    end
    for (int j = 0; j < NB; j++) begin
      s[j] = 8'(sv[j]);
      t[j] = 8'(tv[j]);
    end
    rst    = r;
    issued = 1'b1;
    e.dp = edp; e.scale = esc; e.name = nm;
    q.push_back(e);
  endtask

  function automatic int sat17(input int v);
    if (v > 65535) return 65535;
    if (v < -65536) return -65536;
    return v;
  endfunction

  initial begin
    int xv[C];
    int yv[C];
    int sum;
    int sc;
    checks = 0;
    passes = 0;
    issued = 1'b0;
    rst    = 1'b0;
    for (int i = 0; i < C; i++) begin x[i] = '0; y[i] = '0; end
    for (int j = 0; j < NB; j++) begin s[j] = '0; t[j] = '0; end

    // Reset with non-zero data present, then a vector immediately after release
    apply('{9, 9, 9, 9}, '{9, 9, 9, 9}, '{200, 200}, '{127, 127}, 1'b1, 0, 0, "reset");
    apply('{1, 2, 3, 4}, '{5, 6, 7, 8}, '{127, 127}, '{127, 127}, 1'b0, 70, 127, "equal_scales");
    apply('{1, 2, 2, 2}, '{5, 6, 1, 1}, '{128, 127}, '{127, 127}, 1'b0, 19, 128, "unequal_exact");
    apply('{1, 2, 3, 4}, '{5, 6, 7, 8}, '{128, 127}, '{127, 127}, 1'b0, 43, 128, "truncation");
    apply('{-128, -128, -128, -128}, '{-128, -128, -128, -128}, '{127, 127}, '{127, 127},
          1'b0, 65535, 127, "saturation");
    apply('{1, 2, 3, 4}, '{5, 6, 7, 8}, '{0, 0}, '{0, 0}, 1'b0, 70, 0, "clamp_low");
    apply('{1, 2, 3, 4}, '{5, 6, 7, 8}, '{255, 255}, '{255, 255}, 1'b0, 70, 255, "clamp_high");
    // Block 1 negative, shifted 128 places: collapses to -1
    apply('{1, 0, -1, 0}, '{1, 0, 1, 0}, '{255, 127}, '{127, 127}, 1'b0, 0, 255, "wide_shift_neg");
    // Block 1 positive, shifted 128 places: collapses to 0
    apply('{3, 0, 7, 7}, '{1, 0, 7, 7}, '{255, 127}, '{127, 127}, 1'b0, 3, 255, "wide_shift_pos");
    // Block 1 larger scale; block 0 = -17 >>> 2 = -5, block 1 = 6
    apply('{-1, -2, 1, 1}, '{5, 6, 3, 3}, '{127, 129}, '{127, 127}, 1'b0, 1, 129, "neg_trunc");
    // Reset asserted mid-stream wins over data
    apply('{1, 2, 3, 4}, '{5, 6, 7, 8}, '{127, 127}, '{127, 127}, 1'b1, 0, 0, "reset_priority");

    // Random equal-scale vectors against an integer reference
    for (int n = 0; n < 12; n++) begin
      sum = 0;
      for (int i = 0; i < C; i++) begin
        xv[i] = int'($urandom_range(0, 255)) - 128;
        yv[i] = int'($urandom_range(0, 255)) - 128;
        sum  += xv[i] * yv[i];
      end
      sc = int'($urandom_range(100, 150));
      apply(xv, yv, '{sc, sc}, '{127, 127}, 1'b0, sat17(sum), sc, "random_equal");
    end

    @(negedge clk);
    issued = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() == 0) begin
      passes++;
    end else begin
      $display("FAIL drain: %0d expectations still queued, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
